// File: rtl/clock_set_controller.sv
// Time-of-day counter with a RUN / SET_H / SET_M setting FSM.
// Includes button edge detection, hold-to-auto-increment and blink generation.
module clock_set_controller #(
    parameter logic [2:0] HOLD_HALVES = 3'd2
) (
    input  logic       ck,
    input  logic       reset,
    input  logic       tick_sec,
    input  logic       tick_half,
    input  logic       btn_mode,
    input  logic       btn_up,
    output logic       half_clear,
    output logic [1:0] mode,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       blink
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        SET_H = 2'b01,
        SET_M = 2'b10,
        BAD   = 2'b11
    } state_t;

    state_t     state;
    logic       mode_prev;
    logic       up_prev;
    logic       up_armed;
    logic [2:0] hold_cnt;

    logic mode_edge, up_live, up_edge, auto_inc, setting, do_inc;
    logic sec_wrap, min_wrap, hour_wrap;

    assign mode = state;

    // up_armed keeps a button held across reset release from acting until it is seen low.
    assign mode_edge = btn_mode & ~mode_prev;
    assign up_live   = btn_up & up_armed;
    assign up_edge   = up_live & ~up_prev;
    assign auto_inc  = up_live & tick_half & (hold_cnt == HOLD_HALVES);
    assign setting   = (state == SET_H) || (state == SET_M);
    assign do_inc    = setting & ~mode_edge & (up_edge | auto_inc);

    assign sec_wrap  = (seconds == 6'd59);
    assign min_wrap  = (minutes == 6'd59);
    assign hour_wrap = (hours == 5'd23);

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            hours      <= 5'd0;
            minutes    <= 6'd0;
            seconds    <= 6'd0;
            blink      <= 1'b0;
            half_clear <= 1'b0;
            hold_cnt   <= 3'd0;
            mode_prev  <= 1'b0;
            up_prev    <= 1'b0;
            up_armed   <= 1'b0;
        end else begin
            mode_prev  <= btn_mode;
            up_prev    <= btn_up;
            up_armed   <= up_armed | ~btn_up;
            half_clear <= setting & ~mode_edge & up_edge;

            if (!up_live || up_edge)
                hold_cnt <= 3'd0;
            else if (tick_half && hold_cnt < HOLD_HALVES)
                hold_cnt <= hold_cnt + 3'd1;

            case (state)
                RUN: begin
                    blink <= 1'b0;
                    if (tick_sec) begin
                        seconds <= sec_wrap ? 6'd0 : seconds + 6'd1;
                        if (sec_wrap) begin
                            minutes <= min_wrap ? 6'd0 : minutes + 6'd1;
                            if (min_wrap)
                                hours <= hour_wrap ? 5'd0 : hours + 5'd1;
                        end
                    end
                    if (mode_edge)
                        state <= SET_H;
                end
                SET_H, SET_M: begin
                    if (btn_up)
                        blink <= 1'b0;
                    else if (tick_half)
                        blink <= ~blink;

                    if (mode_edge) begin
                        if (state == SET_H) begin
                            state <= SET_M;
                        end else begin
                            state   <= RUN;
                            seconds <= 6'd0;
                            blink   <= 1'b0;
                        end
                    end else if (do_inc) begin
                        if (state == SET_H)
                            hours <= hour_wrap ? 5'd0 : hours + 5'd1;
                        else
                            minutes <= min_wrap ? 6'd0 : minutes + 6'd1;
                    end
                end
                default: begin
                    state <= RUN;
                    blink <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller: carry chain, setting modes,
// hold/auto-increment, priority cases and asynchronous reset mid-setting.
module tb_clock_set_controller;

    logic       ck = 1'b0;
    logic       reset = 1'b0;
    logic       tick_sec = 1'b0;
    logic       tick_half = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       half_clear;
    logic [1:0] mode;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       blink;

    int errors = 0;
    int checks = 0;
    int hc_count;

    clock_set_controller #(.HOLD_HALVES(3'd2)) dut (
        .ck        (ck),
        .reset     (reset),
        .tick_sec  (tick_sec),
        .tick_half (tick_half),
        .btn_mode  (btn_mode),
        .btn_up    (btn_up),
        .half_clear(half_clear),
        .mode      (mode),
        .hours     (hours),
        .minutes   (minutes),
        .seconds   (seconds),
        .blink     (blink)
    );

    always #5 ck = ~ck;

    task automatic cyc();
        @(posedge ck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s);
        chk({tag, ".h"}, 32'(hours), 32'(h));
        chk({tag, ".m"}, 32'(minutes), 32'(m));
        chk({tag, ".s"}, 32'(seconds), 32'(s));
    endtask

    task automatic mode_pulse();
        btn_mode = 1'b1; cyc();
        btn_mode = 1'b0; cyc();
    endtask

    task automatic up_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            btn_up = 1'b1; cyc();
            btn_up = 1'b0; cyc();
        end
    endtask

    task automatic sec_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            tick_sec = 1'b1; cyc();
            tick_sec = 1'b0; cyc();
        end
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst.mode", 32'(mode), 0);
        chk_time("rst", 0, 0, 0);
        chk("rst.blink", 32'(blink), 0);
        chk("rst.hc", 32'(half_clear), 0);
        cyc();
        reset = 1'b1;
        cyc();

        // Set 23:59 via single presses
        btn_mode = 1'b1; cyc();
        chk("enter_seth", 32'(mode), 1);
        btn_mode = 1'b0; cyc();
        btn_up = 1'b1; cyc();
        chk("first_up.h", 32'(hours), 1);
        chk("first_up.hc", 32'(half_clear), 1);
        btn_up = 1'b0; cyc();
        chk("first_up.hc_off", 32'(half_clear), 0);
        up_pulses(22);
        chk("set_h23", 32'(hours), 23);
        mode_pulse();
        chk("enter_setm", 32'(mode), 2);
        up_pulses(59);
        chk("set_m59", 32'(minutes), 59);
        mode_pulse();
        chk("back_run", 32'(mode), 0);

        // Carry chain 23:59:58 -> 23:59:59 -> 00:00:00
        sec_pulses(58);
        chk_time("t58", 23, 59, 58);
        sec_pulses(1);
        chk_time("t59", 23, 59, 59);
        chk("t59.mode", 32'(mode), 0);
        tick_sec = 1'b1; cyc();
        chk_time("wrap", 0, 0, 0);
        chk("wrap.mode", 32'(mode), 0);
        tick_sec = 1'b0; cyc();

        // RUN ignores btn_up, blink stays low
        btn_up = 1'b1; tick_half = 1'b1; cyc();
        chk("run_up.h", 32'(hours), 0);
        chk("run_up.hc", 32'(half_clear), 0);
        chk("run_blink", 32'(blink), 0);
        btn_up = 1'b0; tick_half = 1'b0; cyc();
        sec_pulses(2);

        // tick_sec and btn_mode together: tick applied, enter SET_H
        tick_sec = 1'b1; btn_mode = 1'b1; cyc();
        chk("tick_mode.s", 32'(seconds), 3);
        chk("tick_mode.mode", 32'(mode), 1);
        tick_sec = 1'b0; btn_mode = 1'b0; cyc();
        tick_sec = 1'b1; cyc();
        chk("seth_tick_ignored", 32'(seconds), 3);
        tick_sec = 1'b0; cyc();

        // Hold from 22 with HOLD_HALVES=2
        up_pulses(22);
        chk("hold.start", 32'(hours), 22);
        hc_count = 0;
        btn_up = 1'b1; cyc();
        chk("hold.edge", 32'(hours), 23);
        hc_count += int'(half_clear);
        for (int k = 1; k <= 8; k++) begin
            tick_half = 1'b1; cyc();
            chk($sformatf("hold.tick%0d", k), 32'(hours), (k <= 2) ? 23 : k - 3);
            chk($sformatf("hold.blink%0d", k), 32'(blink), 0);
            hc_count += int'(half_clear);
            tick_half = 1'b0; cyc();
            hc_count += int'(half_clear);
        end
        chk("hold.hc_count", 32'(hc_count), 1);

        // Release: no increment, blink toggles
        btn_up = 1'b0; cyc();
        tick_half = 1'b1; cyc();
        chk("rel.h", 32'(hours), 5);
        chk("rel.blink1", 32'(blink), 1);
        tick_half = 1'b0; cyc();
        tick_half = 1'b1; cyc();
        chk("rel.blink0", 32'(blink), 0);
        tick_half = 1'b0; cyc();

        // btn_mode and btn_up together: mode wins
        btn_mode = 1'b1; btn_up = 1'b1; cyc();
        chk("both.mode", 32'(mode), 2);
        chk("both.h", 32'(hours), 5);
        chk("both.hc", 32'(half_clear), 0);
        chk("both.m", 32'(minutes), 0);
        btn_mode = 1'b0; btn_up = 1'b0; cyc();
        chk("both.m_after", 32'(minutes), 0);

        // SET_M wrap 59->0 without carry, then exit clears seconds
        up_pulses(59);
        chk("setm.59", 32'(minutes), 59);
        btn_up = 1'b1; cyc();
        chk("setm.wrap_m", 32'(minutes), 0);
        chk("setm.wrap_h", 32'(hours), 5);
        btn_up = 1'b0; cyc();
        chk("setm.s_held", 32'(seconds), 3);
        btn_mode = 1'b1; cyc();
        chk("exit.mode", 32'(mode), 0);
        chk("exit.s", 32'(seconds), 0);
        chk("exit.blink", 32'(blink), 0);
        btn_mode = 1'b0; cyc();

        // Asynchronous reset during auto-increment
        mode_pulse();
        btn_up = 1'b1; cyc();
        chk("ar.edge", 32'(hours), 6);
        for (int k = 0; k < 3; k++) begin
            tick_half = 1'b1; cyc();
            tick_half = 1'b0; cyc();
        end
        chk("ar.auto", 32'(hours), 7);
        #2 reset = 1'b0;
        #1;
        chk("ar.mode", 32'(mode), 0);
        chk_time("ar", 0, 0, 0);
        chk("ar.blink", 32'(blink), 0);
        chk("ar.hc", 32'(half_clear), 0);
        cyc();
        reset = 1'b1;
        mode_pulse();
        chk("ar.seth", 32'(mode), 1);
        for (int k = 0; k < 4; k++) begin
            tick_half = 1'b1; cyc();
            tick_half = 1'b0; cyc();
        end
        chk("ar.held_h", 32'(hours), 0);
        chk("ar.held_hc", 32'(half_clear), 0);
        btn_up = 1'b0; cyc();
        btn_up = 1'b1; cyc();
        chk("ar.rearm_h", 32'(hours), 1);
        chk("ar.rearm_hc", 32'(half_clear), 1);
        btn_up = 1'b0; cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_set_controller.md
CLOCK_SET_CONTROLLER -- requirements
Module: clock_set_controller

Interface
REQ-001 SHALL have parameter HOLD_HALVES, default 3'd2: number of tick_half pulses button btn_up is held before auto-increment starts (legal range 1..7).
REQ-002 SHALL have port ck  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port tick_sec  input  1  one-cycle enable pulse, once per second.
REQ-005 SHALL have port tick_half  input  1  one-cycle enable pulse, once per half second, from the half-second enable generator.
REQ-006 SHALL have port btn_mode  input  1  debounced, synchronised level; rising edge advances the mode.
REQ-007 SHALL have port btn_up  input  1  debounced, synchronised level; increments the selected field.
REQ-008 SHALL have port half_clear  output  1  one-cycle pulse that restarts the half-second generator period.
REQ-009 SHALL have port mode  output  2  current state: 00 RUN, 01 SET_H, 10 SET_M.
REQ-010 SHALL have port hours  output  5  0..23.
REQ-011 SHALL have port minutes  output  6  0..59.
REQ-012 SHALL have port seconds  output  6  0..59.
REQ-013 SHALL have port blink  output  1  display blank phase for the selected field.

Function
REQ-014 SHALL detect rising edges of btn_mode and btn_up with one registered previous-value flop each; edge = current 1 and previous 0.
REQ-015 SHALL implement the FSM RUN -> SET_H -> SET_M -> RUN, advancing one state per btn_mode rising edge; encoding 11 SHALL never occur and, if reached, SHALL return to RUN next cycle.
REQ-016 In RUN, tick_sec SHALL increment seconds; 59->0 SHALL carry +1 to minutes; minutes 59->0 SHALL carry +1 to hours; hours 23->0; all carries in the same cycle (23:59:59 -> 00:00:00 in one edge).
REQ-017 In RUN, btn_up SHALL be ignored and blink SHALL be 0.
REQ-018 In SET_H or SET_M, seconds SHALL hold; tick_sec SHALL be ignored.
REQ-019 In SET_H, an increment SHALL change hours only (23->0, no carry); in SET_M, minutes only (59->0, no carry).
REQ-020 On a btn_up rising edge in SET_H/SET_M, SHALL apply one increment in the next clock edge, clear the hold counter to 0, and pulse half_clear for exactly one cycle.
REQ-021 While btn_up stays 1, each tick_half SHALL increment a 3-bit hold counter (saturating at HOLD_HALVES); once the counter equals HOLD_HALVES, each subsequent tick_half SHALL apply one increment (auto-increment, 2 Hz).
REQ-022 btn_up = 0 SHALL clear the hold counter and stop auto-increment in the same cycle.
REQ-023 blink SHALL toggle on each tick_half in SET_H/SET_M, SHALL be forced to 0 while btn_up = 1, and SHALL be 0 on entry to RUN.
REQ-024 Transition SET_M -> RUN SHALL clear seconds to 0 on that same edge.
REQ-025 Simultaneous btn_mode edge and btn_up edge/auto-increment: the mode change SHALL win; no increment is applied and half_clear SHALL NOT pulse.
REQ-026 Simultaneous tick_sec and btn_mode edge in RUN: the tick SHALL be applied and the state SHALL become SET_H on the same edge.
REQ-027 All outputs SHALL be registered; latency from input event to output change SHALL be exactly one ck edge.

Reset
REQ-028 While reset = 0, SHALL asynchronously force mode=00, hours=0, minutes=0, seconds=0, blink=0, half_clear=0, hold counter=0, edge-detect flops=0.
REQ-029 On reset deassertion mid-setting, SHALL restart in RUN with no pending increment; a btn_up already held at release SHALL NOT count as a rising edge until it has been seen at 0.

Verification
REQ-030 Time 23:59:58 in RUN, two tick_sec pulses -> 23:59:59, then 00:00:00, with mode = 00 throughout.
REQ-031 One btn_mode pulse, then btn_up held for 8 tick_half pulses with HOLD_HALVES = 2 and hours = 22 -> edge gives 23; ticks 1-2 give no change; ticks 3-8 give 0,1,2,3,4,5; half_clear pulses exactly once.
REQ-032 SET_M with minutes = 59, btn_up pulse -> minutes = 0, hours unchanged; second btn_mode pulse -> mode = 00 and seconds = 0.
REQ-033 btn_mode and btn_up rise on the same cycle in SET_H, hours = 5 -> mode = 10, hours = 5, half_clear = 0.
REQ-034 reset driven to 0 asynchronously between edges during auto-increment -> all outputs = 0 immediately; after release with btn_up still 1, no increment occurs until btn_up falls and rises again.
